seq_restoring_divider: RTL and testbench

//   Multi-cycle unsigned restoring divider: the inverse operation of the partial-product multiplier blocks.

---
 rtl/seq_restoring_divider.sv | 116 +++++++++++
 tb/tb_seq_restoring_divider.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first, with registered quotient/remainder.
// Latency: result valid WIDTH+1 edges after accept (1 edge for a zero divisor); one op in flight.
// Backpressure: result held in DONE until out_ready; in_ready returns one cycle after the output handshake.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DZERO, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] q_acc;
  // Stored partial remainder is always < D, so WIDTH bits suffice; the shifted value needs WIDTH+1.
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    cnt;
  // Set after the cnt==0 step so the result lands on a separate transition edge.
  logic             last;

  logic [WIDTH:0]   r_shift;
  logic             fits;

  // Trial step: shift in the next dividend bit and compare against the divisor.
  always_comb begin
    r_shift = {r_acc, n_reg[cnt]};
    fits    = (r_shift >= {1'b0, d_reg});
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      n_reg       <= '0;
      d_reg       <= '0;
      q_acc       <= '0;
      r_acc       <= '0;
      cnt         <= '0;
      last        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            n_reg       <= dividend;
            d_reg       <= divisor;
            q_acc       <= '0;
            r_acc       <= '0;
            cnt         <= CNT_MAX;
            last        <= 1'b0;
            div_by_zero <= 1'b0;
            in_ready    <= 1'b0;
            state       <= (divisor == '0) ? DZERO : CALC;
          end else begin
            in_ready <= 1'b1;
          end
        end
        CALC: begin
          if (last) begin
            quotient  <= q_acc;
            remainder <= r_acc;
            out_valid <= 1'b1;
            last      <= 1'b0;
            state     <= DONE;
          end else begin
            if (fits) begin
              r_acc      <= WIDTH'(r_shift - {1'b0, d_reg});
              q_acc[cnt] <= 1'b1;
            end else begin
              r_acc <= r_shift[WIDTH-1:0];
            end
            if (cnt == '0) begin
              last <= 1'b1;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        DZERO: begin
          quotient    <= '1;
          remainder   <= n_reg;
          div_by_zero <= 1'b1;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed cases plus random/exhaustive streams.
// Expected results come from plain integer division; timing expectations from the handshake rules.
// Two instances: WIDTH=8 (directed + random stream) and WIDTH=2 (exhaustive stream).
module tb_seq_restoring_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0, dbz8;
  logic [7:0] dividend8 = '0, divisor8 = '0, quotient8, remainder8;
  // WIDTH=2 instance
  logic       in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0, dbz2;
  logic [1:0] dividend2 = '0, divisor2 = '0, quotient2, remainder2;

  seq_restoring_divider #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .dividend(dividend8), .divisor(divisor8), .out_valid(out_valid8), .out_ready(out_ready8),
    .quotient(quotient8), .remainder(remainder8), .div_by_zero(dbz8)
  );

  seq_restoring_divider #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .dividend(dividend2), .divisor(divisor2), .out_valid(out_valid2), .out_ready(out_ready2),
    .quotient(quotient2), .remainder(remainder2), .div_by_zero(dbz2)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: quotient/remainder from integer arithmetic, zero divisor per the defined convention.
  function automatic int ref_q(input int n, input int d, input int w);
    return (d == 0) ? ((1 << w) - 1) : (n / d);
  endfunction
  function automatic int ref_r(input int n, input int d);
    return (d == 0) ? n : (n % d);
  endfunction

  task automatic start8(input int n, input int d);
    int k = 0;
    while (!in_ready8 && k < 50) begin tick(); k++; end
    check("in_ready_wait", in_ready8, 1);
    dividend8 = 8'(n);
    divisor8  = 8'(d);
    in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    dividend8 = 8'($urandom);
    divisor8  = 8'($urandom);
    check("in_ready_after_accept", in_ready8, 0);
  endtask

  // Full operation: accept, measure latency, check result; optionally leave the result pending.
  task automatic op8(input int n, input int d, input bit hold);
    int lat = 0;
    start8(n, d);
    while (!out_valid8 && lat < 50) begin tick(); lat++; end
    check("latency", lat, (d == 0) ? 1 : 9);
    check("quotient", quotient8, ref_q(n, d, 8));
    check("remainder", remainder8, ref_r(n, d));
    check("div_by_zero", dbz8, (d == 0) ? 1 : 0);
    if (!hold) begin
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
      check("out_valid_after_hs", out_valid8, 0);
    end
  endtask

  initial begin
    logic [15:0] sb[$];
    logic [15:0] ent;
    logic        acc;
    int          n, d, sent, got, cyc, last_out, qh, rh;
    int          ops_n[$];
    int          ops_d[$];

    // Reset values
    #2;
    check("rst_in_ready", in_ready8, 0);
    check("rst_out_valid", out_valid8, 0);
    check("rst_quotient", quotient8, 0);
    check("rst_remainder", remainder8, 0);
    check("rst_dbz", dbz8, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("in_ready_after_rst", in_ready8, 1);

    // Directed operations
    op8(200, 7, 1'b0);
    op8(255, 1, 1'b0);
    op8(3, 9, 1'b0);
    op8(5, 0, 1'b0);
    op8(10, 3, 1'b0);

    // Backpressure: result held, new operands ignored
    op8(250, 13, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid8 = 1'b1;
      dividend8 = 8'($urandom);
      divisor8  = 8'($urandom);
      tick();
      check("bp_out_valid", out_valid8, 1);
      check("bp_in_ready", in_ready8, 0);
      check("bp_quotient", quotient8, 19);
      check("bp_remainder", remainder8, 3);
    end
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check("bp_release_out_valid", out_valid8, 0);
    check("bp_release_in_ready", in_ready8, 1);
    tick();
    check("idle_no_accept", in_ready8, 1);
    check("idle_keeps_quotient", quotient8, 19);

    // Reset during CALC
    start8(77, 5);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid8, 0);
    check("midrst_quotient", quotient8, 0);
    check("midrst_remainder", remainder8, 0);
    check("midrst_in_ready", in_ready8, 0);
    tick();
    rst_n = 1'b1;
    tick();
    op8(100, 10, 1'b0);

    // Random back-to-back stream, WIDTH=8, out_ready tied high
    sent = 0; got = 0; cyc = 0; last_out = -1;
    out_ready8 = 1'b1;
    in_valid8  = 1'b1;
    dividend8  = 8'($urandom_range(0, 255));
    divisor8   = 8'($urandom_range(1, 255));
    while (got < 1500 && cyc < 30000) begin
      acc = in_valid8 && in_ready8;
      if (out_valid8) begin
        if (sb.size() == 0) begin
          check("sb8_empty", 1, 0);
        end else begin
          ent = sb.pop_front();
          n = int'(ent[15:8]); d = int'(ent[7:0]);
          qh = int'(quotient8); rh = int'(remainder8);
          check("s8_quotient", qh, ref_q(n, d, 8));
          check("s8_remainder", rh, ref_r(n, d));
          check("s8_invariant", qh * d + rh, n);
          check("s8_r_lt_d", (rh < d) ? 1 : 0, 1);
          check("s8_dbz", dbz8, 0);
        end
        if (last_out >= 0) check("s8_gap", cyc - last_out, 11);
        last_out = cyc;
        got++;
      end
      if (acc) begin sb.push_back({dividend8, divisor8}); sent++; end
      tick();
      cyc++;
      if (acc) begin
        if (sent < 1500) begin
          dividend8 = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
          divisor8  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(1, 255));
        end else begin
          in_valid8 = 1'b0;
        end
      end
    end
    check("s8_count", got, 1500);
    in_valid8 = 1'b0;
    out_ready8 = 1'b0;

    // Exhaustive stream, WIDTH=2, nonzero divisors
    for (int i = 0; i < 4; i++)
      for (int j = 1; j < 4; j++) begin ops_n.push_back(i); ops_d.push_back(j); end
    sb.delete();
    sent = 0; got = 0; cyc = 0; last_out = -1;
    out_ready2 = 1'b1;
    in_valid2  = 1'b1;
    dividend2  = 2'(ops_n[0]);
    divisor2   = 2'(ops_d[0]);
    while (got < ops_n.size() && cyc < 2000) begin
      acc = in_valid2 && in_ready2;
      if (out_valid2) begin
        if (sb.size() == 0) begin
          check("sb2_empty", 1, 0);
        end else begin
          ent = sb.pop_front();
          n = int'(ent[15:8]); d = int'(ent[7:0]);
          qh = int'(quotient2); rh = int'(remainder2);
          check("s2_quotient", qh, ref_q(n, d, 2));
          check("s2_remainder", rh, ref_r(n, d));
          check("s2_invariant", qh * d + rh, n);
          check("s2_r_lt_d", (rh < d) ? 1 : 0, 1);
        end
        if (last_out >= 0) check("s2_gap", cyc - last_out, 5);
        last_out = cyc;
        got++;
      end
      if (acc) begin sb.push_back({6'd0, dividend2, 6'd0, divisor2}); sent++; end
      tick();
      cyc++;
      if (acc) begin
        if (sent < ops_n.size()) begin
          dividend2 = 2'(ops_n[sent]);
          divisor2  = 2'(ops_d[sent]);
        end else begin
          in_valid2 = 1'b0;
        end
      end
    end
    check("s2_count", got, ops_n.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
